// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the three-master memory arbiter.
// Master indices: 0 = instruction fetch, 1 = data, 2 = DMA.
package mem_arb_pkg;

    localparam int          NUM_MASTERS        = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEF_ERR_DATA       = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Next master index in the round-robin ring (0 -> 1 -> 2 -> 0).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: searches last+1, last+2, last+0 (mod 3)
// and returns the first requesting master.
module rr_priority_picker
    import mem_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [1:0]             i_last,
    output logic [1:0]             o_idx,
    output logic                   o_valid
);

    // Padded to four entries so a 2-bit index never falls outside the vector.
    logic [3:0] w_req4;
    assign w_req4 = {1'b0, i_req};

    always_comb begin
        logic [1:0] cand;
        o_idx   = 2'd0;
        o_valid = 1'b0;
        cand    = rr_next(i_last);
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!o_valid && w_req4[cand]) begin
                o_idx   = cand;
                o_valid = 1'b1;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter giving three masters one-at-a-time access to a single
// memory port, with a per-access timeout that returns ERR_DATA and an error flag.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_rd_i,
    input  logic        m0_wr_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_ready_o,
    output logic [31:0] m0_data_o,
    output logic        m0_err_o,

    input  logic        m1_rd_i,
    input  logic        m1_wr_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_ready_o,
    output logic [31:0] m1_data_o,
    output logic        m1_err_o,

    input  logic        m2_rd_i,
    input  logic        m2_wr_i,
    input  logic [31:0] m2_addr_i,
    input  logic [31:0] m2_data_i,
    output logic        m2_ready_o,
    output logic [31:0] m2_data_o,
    output logic        m2_err_o,

    input  logic        mem_ready_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,

    output logic [1:0]  grant_o,
    output logic        busy_o
);

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES);

    arb_state_e r_state, w_state_nxt;

    logic [1:0]             r_grant;
    logic [1:0]             r_last_grant;
    logic [7:0]             r_cnt;
    logic                   r_mem_rd;
    logic                   r_mem_wr;
    logic [31:0]            r_mem_addr;
    logic [31:0]            r_mem_data;
    logic [NUM_MASTERS-1:0] r_ready;
    logic [NUM_MASTERS-1:0] r_err;
    logic [31:0]            r_mdata [NUM_MASTERS];

    logic [NUM_MASTERS-1:0] w_req_rd;
    logic [NUM_MASTERS-1:0] w_req_wr;
    logic [NUM_MASTERS-1:0] w_req;
    logic [31:0]            w_req_addr [NUM_MASTERS];
    logic [31:0]            w_req_data [NUM_MASTERS];
    logic [1:0]             w_pick_idx;
    logic                   w_pick_vld;
    logic                   w_sel_rd;
    logic                   w_sel_wr;
    logic [31:0]            w_sel_addr;
    logic [31:0]            w_sel_data;
    logic [7:0]             w_cnt_inc;
    logic                   w_timeout;
    logic                   w_done;
    logic                   w_tmo_err;
    logic [NUM_MASTERS-1:0] w_grant_oh;

    assign w_req_rd      = {m2_rd_i, m1_rd_i, m0_rd_i};
    assign w_req_wr      = {m2_wr_i, m1_wr_i, m0_wr_i};
    assign w_req         = w_req_rd | w_req_wr;
    assign w_req_addr[0] = m0_addr_i;
    assign w_req_addr[1] = m1_addr_i;
    assign w_req_addr[2] = m2_addr_i;
    assign w_req_data[0] = m0_data_i;
    assign w_req_data[1] = m1_data_i;
    assign w_req_data[2] = m2_data_i;

    rr_priority_picker u_picker (
        .i_req   (w_req),
        .i_last  (r_last_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_vld)
    );

    always_comb begin
        w_sel_rd   = 1'b0;
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (w_pick_idx == 2'(m)) begin
                w_sel_rd   = w_req_rd[m];
                w_sel_wr   = w_req_wr[m];
                w_sel_addr = w_req_addr[m];
                w_sel_data = w_req_data[m];
            end
        end
    end

    // A memory completion on the timeout cycle wins: the access is a success.
    assign w_cnt_inc  = r_cnt + 8'd1;
    assign w_timeout  = (w_cnt_inc == TMO_LIM);
    assign w_done     = (r_state == ST_ACCESS) && (mem_ready_i || w_timeout);
    assign w_tmo_err  = !mem_ready_i && w_timeout;
    assign w_grant_oh = 3'b001 << r_grant;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_pick_vld) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_done)     w_state_nxt = ST_RESP;
            ST_RESP:                   w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant      <= 2'd0;
            r_last_grant <= 2'd2;
            r_cnt        <= 8'd0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_ready      <= '0;
            r_err        <= '0;
            for (int m = 0; m < NUM_MASTERS; m++) r_mdata[m] <= '0;
        end else begin
            // The ready/err pulse lives exactly in the single RESP cycle.
            r_ready <= w_done ? w_grant_oh : '0;
            r_err   <= (w_done && w_tmo_err) ? w_grant_oh : '0;

            if (r_state == ST_IDLE && w_pick_vld) begin
                r_grant      <= w_pick_idx;
                r_last_grant <= w_pick_idx;
                r_cnt        <= 8'd0;
                r_mem_wr     <= w_sel_wr;
                r_mem_rd     <= w_sel_rd && !w_sel_wr;
                r_mem_addr   <= w_sel_addr;
                r_mem_data   <= w_sel_data;
            end

            if (r_state == ST_ACCESS) r_cnt <= w_cnt_inc;

            if (w_done) begin
                r_mem_rd <= 1'b0;
                r_mem_wr <= 1'b0;
                for (int m = 0; m < NUM_MASTERS; m++) begin
                    if (r_mem_rd && r_grant == 2'(m))
                        r_mdata[m] <= w_tmo_err ? ERR_DATA : mem_data_i;
                end
            end
        end
    end

    assign mem_rd_o   = r_mem_rd;
    assign mem_wr_o   = r_mem_wr;
    assign mem_addr_o = r_mem_addr;
    assign mem_data_o = r_mem_data;
    assign grant_o    = r_grant;
    assign busy_o     = (r_state != ST_IDLE);

    assign m0_ready_o = r_ready[0];
    assign m1_ready_o = r_ready[1];
    assign m2_ready_o = r_ready[2];
    assign m0_err_o   = r_err[0];
    assign m1_err_o   = r_err[1];
    assign m2_err_o   = r_err[2];
    assign m0_data_o  = r_mdata[0];
    assign m1_data_o  = r_mdata[1];
    assign m2_data_o  = r_mdata[2];

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_mem_rr_arbiter;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    localparam int          TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  b_rd = '0;
    logic [2:0]  b_wr = '0;
    logic [31:0] b_addr [3];
    logic [31:0] b_wdata [3];
    logic        mem_ready = 1'b0;
    logic [31:0] mem_data = '0;

    logic        rdy0, rdy1, rdy2, err0, err1, err2;
    logic [31:0] dout [3];
    logic        mem_rd, mem_wr, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  grant;
    logic [2:0]  rdy_v, err_v;

    int          checks = 0;
    int          errors = 0;
    int          last_grant = 2;
    logic [31:0] exp_data [3];

    assign rdy_v = {rdy2, rdy1, rdy0};
    assign err_v = {err2, err1, err0};

    always #5 clk = ~clk;

    mem_rr_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_rd_i(b_rd[0]), .m0_wr_i(b_wr[0]), .m0_addr_i(b_addr[0]), .m0_data_i(b_wdata[0]),
        .m0_ready_o(rdy0), .m0_data_o(dout[0]), .m0_err_o(err0),
        .m1_rd_i(b_rd[1]), .m1_wr_i(b_wr[1]), .m1_addr_i(b_addr[1]), .m1_data_i(b_wdata[1]),
        .m1_ready_o(rdy1), .m1_data_o(dout[1]), .m1_err_o(err1),
        .m2_rd_i(b_rd[2]), .m2_wr_i(b_wr[2]), .m2_addr_i(b_addr[2]), .m2_data_i(b_wdata[2]),
        .m2_ready_o(rdy2), .m2_data_o(dout[2]), .m2_err_o(err2),
        .mem_ready_i(mem_ready), .mem_data_i(mem_data),
        .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .grant_o(grant), .busy_o(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rule: search last+1, last+2, last+0 modulo 3.
    function automatic int rr_pick(input logic [2:0] req, input int last);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic new_req(input int m);
        int op;
        op         = $urandom_range(0, 2);
        b_rd[m]    = (op != 1);
        b_wr[m]    = (op != 0);
        b_addr[m]  = $urandom;
        b_wdata[m] = $urandom;
    endtask

    task automatic model_reset();
        last_grant = 2;
        for (int m = 0; m < 3; m++) exp_data[m] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        model_reset();
        checks += 6;
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (grant !== 2'd0)     begin errors++; $display("FAIL reset_grant: got %0d want 0", grant); end
        if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_memreq: got %b want 00", {mem_rd, mem_wr}); end
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_memaddr: got %h/%h want 0/0", mem_addr, mem_wdata); end
        if (rdy_v !== 3'b000 || err_v !== 3'b000) begin errors++; $display("FAIL reset_rdyerr: got %b/%b want 000/000", rdy_v, err_v); end
        if (dout[0] !== 32'h0 || dout[1] !== 32'h0 || dout[2] !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h %h %h want 0", dout[0], dout[1], dout[2]); end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: busy got %b want 0", busy); end
    endtask

    task automatic test_single_read();
        b_rd[0] = 1'b1; b_addr[0] = 32'h100;
        step();
        last_grant = 0;
        checks += 3;
        if (busy !== 1'b1 || grant !== 2'd0) begin errors++; $display("FAIL sr_grant: got busy=%b grant=%0d want 1/0", busy, grant); end
        if ({mem_rd, mem_wr} !== 2'b10) begin errors++; $display("FAIL sr_memreq: got %b want 10", {mem_rd, mem_wr}); end
        if (mem_addr !== 32'h100) begin errors++; $display("FAIL sr_addr: got %h want 00000100", mem_addr); end
        mem_ready = 1'b1; mem_data = 32'hCAFE_0001;
        step();
        exp_data[0] = 32'hCAFE_0001;
        mem_ready = 1'b0; b_rd[0] = 1'b0;
        checks += 3;
        if (rdy_v !== 3'b001 || err_v !== 3'b000) begin errors++; $display("FAIL sr_ready: got rdy=%b err=%b want 001/000", rdy_v, err_v); end
        if (dout[0] !== 32'hCAFE_0001) begin errors++; $display("FAIL sr_data: got %h want cafe0001", dout[0]); end
        if (mem_rd !== 1'b0) begin errors++; $display("FAIL sr_memrd_drop: got %b want 0", mem_rd); end
        step();
        checks++;
        if (rdy_v !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL sr_oneshot: got rdy=%b busy=%b want 000/0", rdy_v, busy); end
    endtask

    task automatic test_timeout();
        b_rd[1] = 1'b1; b_addr[1] = 32'h200;
        step();
        last_grant = 1;
        checks++;
        if (grant !== 2'd1 || mem_rd !== 1'b1) begin errors++; $display("FAIL to_grant: got grant=%0d rd=%b want 1/1", grant, mem_rd); end
        for (int c = 1; c < TMO; c++) begin
            step();
            checks++;
            if (mem_rd !== 1'b1 || rdy_v !== 3'b000) begin errors++; $display("FAIL to_wait%0d: got rd=%b rdy=%b want 1/000", c, mem_rd, rdy_v); end
        end
        step();
        exp_data[1] = ERR;
        b_rd[1] = 1'b0;
        checks += 3;
        if (mem_rd !== 1'b0) begin errors++; $display("FAIL to_drop: got %b want 0", mem_rd); end
        if (rdy_v !== 3'b010 || err_v !== 3'b010) begin errors++; $display("FAIL to_flags: got rdy=%b err=%b want 010/010", rdy_v, err_v); end
        if (dout[1] !== ERR) begin errors++; $display("FAIL to_data: got %h want %h", dout[1], ERR); end
        step();
    endtask

    task automatic test_rdwr_both();
        b_rd[2] = 1'b1; b_wr[2] = 1'b1; b_addr[2] = 32'h20; b_wdata[2] = 32'h55;
        step();
        last_grant = 2;
        checks += 2;
        if (grant !== 2'd2 || {mem_rd, mem_wr} !== 2'b01) begin errors++; $display("FAIL rw_req: got grant=%0d rdwr=%b want 2/01", grant, {mem_rd, mem_wr}); end
        if (mem_addr !== 32'h20 || mem_wdata !== 32'h55) begin errors++; $display("FAIL rw_addr: got %h/%h want 20/55", mem_addr, mem_wdata); end
        mem_ready = 1'b1; mem_data = 32'h1234_5678;
        step();
        mem_ready = 1'b0; b_rd[2] = 1'b0; b_wr[2] = 1'b0;
        checks += 2;
        if (rdy_v !== 3'b100 || err_v !== 3'b000) begin errors++; $display("FAIL rw_ready: got rdy=%b err=%b want 100/000", rdy_v, err_v); end
        if (dout[2] !== exp_data[2]) begin errors++; $display("FAIL rw_nodata: got %h want %h", dout[2], exp_data[2]); end
        step();
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 2, 0};
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        for (int m = 0; m < 3; m++) begin
            b_rd[m] = 1'b1; b_wr[m] = 1'b0; b_addr[m] = 32'h1000 + 32'(m) * 32'h10;
        end
        for (int k = 0; k < 4; k++) begin
            int w;
            w = order[k];
            step();
            last_grant = w;
            checks += 2;
            if (grant !== 2'(w)) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", k, grant, w); end
            if (mem_addr !== b_addr[w]) begin errors++; $display("FAIL rr_addr%0d: got %h want %h", k, mem_addr, b_addr[w]); end
            mem_ready = 1'b1; mem_data = 32'hA0 + 32'(k);
            step();
            exp_data[w] = 32'hA0 + 32'(k);
            mem_ready = 1'b0;
            checks += 2;
            if (rdy_v !== 3'(1 << w)) begin errors++; $display("FAIL rr_ready%0d: got %b want %b", k, rdy_v, 3'(1 << w)); end
            if (dout[w] !== exp_data[w]) begin errors++; $display("FAIL rr_data%0d: got %h want %h", k, dout[w], exp_data[w]); end
            if (k != 0) b_rd[w] = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid_access();
        b_rd[0] = 1'b1; b_addr[0] = 32'h300;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        checks += 4;
        if (busy !== 1'b0 || grant !== 2'd0) begin errors++; $display("FAIL rm_state: got busy=%b grant=%0d want 0/0", busy, grant); end
        if ({mem_rd, mem_wr} !== 2'b00 || mem_addr !== 32'h0) begin errors++; $display("FAIL rm_mem: got rdwr=%b addr=%h want 00/0", {mem_rd, mem_wr}, mem_addr); end
        if (rdy_v !== 3'b000) begin errors++; $display("FAIL rm_noready: got %b want 000", rdy_v); end
        if (dout[0] !== 32'h0 || dout[1] !== 32'h0 || dout[2] !== 32'h0) begin errors++; $display("FAIL rm_dout: got %h %h %h want 0", dout[0], dout[1], dout[2]); end
        step();
        last_grant = 0;
        checks++;
        if (busy !== 1'b1 || grant !== 2'd0 || mem_rd !== 1'b1) begin errors++; $display("FAIL rm_regrant: got busy=%b grant=%0d rd=%b want 1/0/1", busy, grant, mem_rd); end
        mem_ready = 1'b1; mem_data = 32'h0BAD_F00D;
        step();
        exp_data[0] = 32'h0BAD_F00D;
        mem_ready = 1'b0; b_rd[0] = 1'b0;
        checks++;
        if (rdy_v !== 3'b001 || dout[0] !== 32'h0BAD_F00D) begin errors++; $display("FAIL rm_ready: got rdy=%b data=%h want 001/0badf00d", rdy_v, dout[0]); end
        step();
    endtask

    task automatic test_spurious_ready();
        int w;
        mem_ready = 1'b1; mem_data = 32'hFFFF_FFFF;
        step();
        checks++;
        if (busy !== 1'b0 || rdy_v !== 3'b000 || dout[1] !== exp_data[1]) begin errors++; $display("FAIL sp_idle: got busy=%b rdy=%b d1=%h want 0/000/%h", busy, rdy_v, dout[1], exp_data[1]); end
        mem_ready = 1'b0;
        b_rd[1] = 1'b1; b_addr[1] = 32'h440;
        w = rr_pick(3'b010, last_grant);
        step();
        last_grant = w;
        mem_ready = 1'b1; mem_data = 32'h1111_2222;
        step();
        exp_data[1] = 32'h1111_2222;
        b_rd[1] = 1'b0;
        mem_data = 32'h3333_4444;
        step();
        checks++;
        if (rdy_v !== 3'b000 || dout[1] !== exp_data[1]) begin errors++; $display("FAIL sp_resp: got rdy=%b d1=%h want 000/%h", rdy_v, dout[1], exp_data[1]); end
        step();
        mem_ready = 1'b0;
        checks++;
        if (rdy_v !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL sp_after: got rdy=%b busy=%b want 000/0", rdy_v, busy); end
    endtask

    task automatic test_random();
        int          w, lat;
        logic        isrd, iswr, terr;
        logic [31:0] a_exp, d_exp, rdat;
        rdat = '0;
        for (int t = 0; t < 200; t++) begin
            for (int m = 0; m < 3; m++)
                if (!(b_rd[m] | b_wr[m]) && $urandom_range(0, 1) == 0) new_req(m);
            w = rr_pick(b_rd | b_wr, last_grant);
            if (w < 0) begin
                step();
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle t=%0d: busy got %b want 0", t, busy); end
                continue;
            end
            isrd  = b_rd[w] & ~b_wr[w];
            iswr  = b_wr[w];
            a_exp = b_addr[w];
            d_exp = b_wdata[w];
            step();
            last_grant = w;
            checks += 3;
            if (busy !== 1'b1 || grant !== 2'(w)) begin errors++; $display("FAIL rnd_grant t=%0d: got busy=%b grant=%0d want 1/%0d", t, busy, grant, w); end
            if ({mem_rd, mem_wr} !== {isrd, iswr}) begin errors++; $display("FAIL rnd_op t=%0d: got %b want %b", t, {mem_rd, mem_wr}, {isrd, iswr}); end
            if (mem_addr !== a_exp || mem_wdata !== d_exp) begin errors++; $display("FAIL rnd_addr t=%0d: got %h/%h want %h/%h", t, mem_addr, mem_wdata, a_exp, d_exp); end
            lat = $urandom_range(1, 6);
            for (int c = 1; c <= TMO; c++) begin
                mem_ready = (c == lat);
                mem_data  = $urandom;
                if (c == lat) rdat = mem_data;
                for (int m = 0; m < 3; m++)
                    if (m != w && !(b_rd[m] | b_wr[m]) && $urandom_range(0, 3) == 0) new_req(m);
                step();
                if (c == lat || c == TMO) break;
                checks++;
                if ({mem_rd, mem_wr} !== {isrd, iswr} || mem_addr !== a_exp || rdy_v !== 3'b000) begin
                    errors++; $display("FAIL rnd_hold t=%0d c=%0d: got rdwr=%b addr=%h rdy=%b want %b/%h/000", t, c, {mem_rd, mem_wr}, mem_addr, rdy_v, {isrd, iswr}, a_exp);
                end
            end
            terr = (lat > TMO);
            if (isrd) exp_data[w] = terr ? ERR : rdat;
            checks += 3;
            if (rdy_v !== 3'(1 << w)) begin errors++; $display("FAIL rnd_ready t=%0d: got %b want %b", t, rdy_v, 3'(1 << w)); end
            if (err_v !== (terr ? 3'(1 << w) : 3'b000)) begin errors++; $display("FAIL rnd_err t=%0d lat=%0d: got %b want %b", t, lat, err_v, terr ? 3'(1 << w) : 3'b000); end
            if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL rnd_drop t=%0d: got %b want 00", t, {mem_rd, mem_wr}); end
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (dout[m] !== exp_data[m]) begin errors++; $display("FAIL rnd_data t=%0d m%0d: got %h want %h", t, m, dout[m], exp_data[m]); end
            end
            b_rd[w] = 1'b0; b_wr[w] = 1'b0;
            if ($urandom_range(0, 2) == 0) new_req(w);
            mem_ready = 1'($urandom_range(0, 1));
            mem_data  = $urandom;
            step();
            mem_ready = 1'b0;
            checks += 2;
            if (rdy_v !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rnd_resp_end t=%0d: got rdy=%b busy=%b want 000/0", t, rdy_v, busy); end
            if (dout[w] !== exp_data[w]) begin errors++; $display("FAIL rnd_hold_data t=%0d: got %h want %h", t, dout[w], exp_data[w]); end
        end
    endtask

    initial begin
        for (int m = 0; m < 3; m++) begin
            b_addr[m]   = '0;
            b_wdata[m]  = '0;
            exp_data[m] = '0;
        end
        test_reset();
        test_single_read();
        test_timeout();
        test_rdwr_both();
        test_round_robin();
        test_reset_mid_access();
        test_spurious_ready();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
